// File: rtl/conv1_lif_update.sv
// Conv1 LIF neuron stage: integrates per-channel membrane increments for a 2x2 pixel group,
// fires on threshold crossing and sweeps the membrane array to zero on reset or request.
module conv1_lif_update #(
    parameter int unsigned CONV1_CHANNEL_NUM_O  = 128,
    parameter int unsigned CONV1_CHANNEL_O_WIDE = 8,
    parameter int unsigned MP_WIDE              = 16,
    parameter int          V_TH                 = 64,
    parameter bit          RESET_MODE           = 1'b0
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic signed [MP_WIDE-1:0]       MP_1,
    input  logic signed [MP_WIDE-1:0]       MP_2,
    input  logic signed [MP_WIDE-1:0]       MP_3,
    input  logic signed [MP_WIDE-1:0]       MP_4,
    input  logic [CONV1_CHANNEL_O_WIDE-1:0] channel_o,
    input  logic                            MP_valid,
    input  logic                            clear_req,
    output logic [3:0]                      spike,
    output logic [CONV1_CHANNEL_O_WIDE-1:0] spike_channel,
    output logic                            spike_valid,
    output logic                            busy,
    output logic                            clear_done,
    output logic [15:0]                     spike_cnt,
    output logic                            overrun
);

    localparam int unsigned PIX       = 4;
    localparam int unsigned CW        = CONV1_CHANNEL_O_WIDE;
    localparam int unsigned IDX_W     = (CONV1_CHANNEL_NUM_O > 1) ? $clog2(CONV1_CHANNEL_NUM_O) : 1;
    localparam int unsigned SUM_W     = MP_WIDE + 2;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned CNT_SUM_W = CNT_W + 1;
    localparam int unsigned POP_W     = 3;

    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(CONV1_CHANNEL_NUM_O - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX  = SUM_W'((64'sd1 <<< (MP_WIDE - 1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0] SAT_MIN  = SUM_W'(-(64'sd1 <<< (MP_WIDE - 1)));
    localparam logic signed [SUM_W-1:0] TH       = SUM_W'(V_TH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic [CW-1:0]            ch;
        logic [PIX*MP_WIDE-1:0]   mp;
    } op_t;

    // Membrane storage; intentionally not reset, the sweep after reset zeroes it.
    logic signed [MP_WIDE-1:0] v_mem [CONV1_CHANNEL_NUM_O][PIX];

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 done_c;
    logic                 accept_c;
    logic                 overrun_set_c;
    logic                 in_range_c;
    op_t                  op_in_c;
    op_t                  stage_q;
    logic                 s_valid_q;
    logic [IDX_W-1:0]     s_idx_c;

    logic signed [MP_WIDE-1:0] cur_c  [PIX];
    logic signed [SUM_W-1:0]   sum_c  [PIX];
    logic signed [SUM_W-1:0]   sat_c  [PIX];
    logic signed [MP_WIDE-1:0] next_c [PIX];
    logic [PIX-1:0]            fire_c;
    logic [CNT_SUM_W-1:0]      cnt_sum_c;

    function automatic logic signed [SUM_W-1:0] sat(input logic signed [SUM_W-1:0] x);
        if (x > SAT_MAX) return SAT_MAX;
        if (x < SAT_MIN) return SAT_MIN;
        return x;
    endfunction

    function automatic logic [POP_W-1:0] popcnt(input logic [PIX-1:0] b);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < PIX; i++) n = n + POP_W'(b[i]);
        return n;
    endfunction

    assign op_in_c.ch    = channel_o;
    assign op_in_c.mp    = {MP_4, MP_3, MP_2, MP_1};
    assign in_range_c    = (32'(channel_o) < CONV1_CHANNEL_NUM_O);
    assign accept_c      = MP_valid && (state_q == ST_IDLE) && !clear_req && in_range_c;
    assign overrun_set_c = MP_valid && ((state_q == ST_CLEAR) || clear_req);
    assign s_idx_c       = stage_q.ch[IDX_W-1:0];

    // Next-state logic for the clear sweep
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (clear_req) begin
                    idx_d = '0;
                end else if (idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    done_c  = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    // Integrate, saturate, threshold and reset the staged op; the stored value read here
    // already reflects a write made on the same edge the op was staged.
    always_comb begin
        fire_c = '0;
        for (int k = 0; k < PIX; k++) begin
            cur_c[k]  = v_mem[s_idx_c][k];
            sum_c[k]  = SUM_W'(cur_c[k]) + SUM_W'($signed(stage_q.mp[k*MP_WIDE +: MP_WIDE]));
            sat_c[k]  = sat(sum_c[k]);
            fire_c[k] = (sat_c[k] >= TH);
            if (!fire_c[k]) begin
                next_c[k] = MP_WIDE'(sat_c[k]);
            end else if (RESET_MODE) begin
                next_c[k] = '0;
            end else begin
                next_c[k] = MP_WIDE'(sat(sat_c[k] - TH));
            end
        end
        cnt_sum_c = {1'b0, spike_cnt} + CNT_SUM_W'(popcnt(fire_c));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_CLEAR;
            idx_q         <= '0;
            busy          <= 1'b1;
            clear_done    <= 1'b0;
            stage_q       <= '0;
            s_valid_q     <= 1'b0;
            spike         <= '0;
            spike_channel <= '0;
            spike_valid   <= 1'b0;
            spike_cnt     <= '0;
            overrun       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            busy        <= (state_d == ST_CLEAR);
            clear_done  <= done_c;
            s_valid_q   <= accept_c;
            spike_valid <= s_valid_q;
            overrun     <= overrun | overrun_set_c;
            if (accept_c) begin
                stage_q <= op_in_c;
            end
            if (s_valid_q) begin
                spike         <= fire_c;
                spike_channel <= stage_q.ch;
            end
            if (state_d == ST_CLEAR) begin
                spike_cnt <= '0;
            end else if (s_valid_q) begin
                spike_cnt <= cnt_sum_c[CNT_W] ? '1 : cnt_sum_c[CNT_W-1:0];
            end
        end
    end

    // Array write port: sweep zeroing or the staged op's updated potentials
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            for (int k = 0; k < PIX; k++) v_mem[idx_q][k] <= '0;
        end else if (s_valid_q) begin
            for (int k = 0; k < PIX; k++) v_mem[s_idx_c][k] <= next_c[k];
        end
    end

endmodule

// File: tb/tb_conv1_lif_update.sv
// Bench for conv1_lif_update: soft- and hard-reset instances share stimulus and are
// compared every cycle against an arithmetic model of the membrane array.
module tb_conv1_lif_update;

    localparam int NUM  = 128;
    localparam int CW   = 8;
    localparam int MW   = 16;
    localparam int VTH  = 64;
    localparam int VMAX = 32767;
    localparam int VMIN = -32768;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic signed [MW-1:0] mp1, mp2, mp3, mp4;
    logic [CW-1:0]        ch;
    logic                 mp_valid, clear_req;

    logic [3:0]    spk    [2];
    logic [CW-1:0] spk_ch [2];
    logic          spk_v  [2];
    logic          bsy    [2];
    logic          cdone  [2];
    logic [15:0]   scnt   [2];
    logic          ovr    [2];

    always #5 clk = ~clk;

    conv1_lif_update #(.CONV1_CHANNEL_NUM_O(NUM), .CONV1_CHANNEL_O_WIDE(CW), .MP_WIDE(MW),
                       .V_TH(VTH), .RESET_MODE(1'b0)) dut_soft (
        .clk(clk), .rstn(rstn), .MP_1(mp1), .MP_2(mp2), .MP_3(mp3), .MP_4(mp4),
        .channel_o(ch), .MP_valid(mp_valid), .clear_req(clear_req),
        .spike(spk[0]), .spike_channel(spk_ch[0]), .spike_valid(spk_v[0]), .busy(bsy[0]),
        .clear_done(cdone[0]), .spike_cnt(scnt[0]), .overrun(ovr[0]));

    conv1_lif_update #(.CONV1_CHANNEL_NUM_O(NUM), .CONV1_CHANNEL_O_WIDE(CW), .MP_WIDE(MW),
                       .V_TH(VTH), .RESET_MODE(1'b1)) dut_hard (
        .clk(clk), .rstn(rstn), .MP_1(mp1), .MP_2(mp2), .MP_3(mp3), .MP_4(mp4),
        .channel_o(ch), .MP_valid(mp_valid), .clear_req(clear_req),
        .spike(spk[1]), .spike_channel(spk_ch[1]), .spike_valid(spk_v[1]), .busy(bsy[1]),
        .clear_done(cdone[1]), .spike_cnt(scnt[1]), .overrun(ovr[1]));

    int checks = 0;
    int errors = 0;

    // Reference state: membrane values per mode, sweep cycles left, expected outputs in flight
    int            vm [2][NUM][4];
    int            rem;
    bit            done_exp;
    bit            ovr_exp;
    int            cnt_exp [2];
    bit            clr_last;
    bit            r1_v, r2_v;
    logic [CW-1:0] r1_ch, r2_ch;
    logic [3:0]    r1_sp [2];
    logic [3:0]    r2_sp [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rem      = NUM;
        done_exp = 1'b0;
        ovr_exp  = 1'b0;
        clr_last = 1'b0;
        r1_v     = 1'b0;
        r2_v     = 1'b0;
        r1_ch    = '0;
        r2_ch    = '0;
        for (int m = 0; m < 2; m++) begin
            cnt_exp[m] = 0;
            r1_sp[m]   = '0;
            r2_sp[m]   = '0;
            for (int c = 0; c < NUM; c++)
                for (int k = 0; k < 4; k++) vm[m][c][k] = 0;
        end
    endtask

    // One clock: check outputs, drive this cycle's inputs, advance the model. Starts and ends at a negedge.
    task automatic step(input bit v, input int c, input int a0, input int a1, input int a2,
                        input int a3, input bit clr);
        int mpv [4];
        int s;
        bit busy_now;
        bit acc;
        mpv[0] = a0; mpv[1] = a1; mpv[2] = a2; mpv[3] = a3;
        for (int m = 0; m < 2; m++) begin
            if (clr_last) cnt_exp[m] = 0;
            else if (r2_v) begin
                cnt_exp[m] = cnt_exp[m] + $countones(r2_sp[m]);
                if (cnt_exp[m] > 65535) cnt_exp[m] = 65535;
            end
        end
        busy_now = (rem > 0);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("spike_valid[%0d]", m), 32'(spk_v[m]), 32'(r2_v));
            if (r2_v) begin
                check($sformatf("spike[%0d]", m), 32'(spk[m]), 32'(r2_sp[m]));
                check($sformatf("spike_channel[%0d]", m), 32'(spk_ch[m]), 32'(r2_ch));
            end
            check($sformatf("spike_cnt[%0d]", m), 32'(scnt[m]), 32'(cnt_exp[m]));
            check($sformatf("busy[%0d]", m), 32'(bsy[m]), 32'(busy_now));
            check($sformatf("clear_done[%0d]", m), 32'(cdone[m]), 32'(done_exp));
            check($sformatf("overrun[%0d]", m), 32'(ovr[m]), 32'(ovr_exp));
        end

        acc = v && !busy_now && !clr && (c >= 0) && (c < NUM);
        if (v && (busy_now || clr)) ovr_exp = 1'b1;
        r2_v  = r1_v;
        r2_ch = r1_ch;
        r2_sp = r1_sp;
        r1_v  = acc;
        r1_ch = CW'(c);
        if (acc) begin
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < 4; k++) begin
                    s = vm[m][c][k] + mpv[k];
                    if (s > VMAX) s = VMAX;
                    else if (s < VMIN) s = VMIN;
                    if (s >= VTH) begin
                        r1_sp[m][k] = 1'b1;
                        vm[m][c][k] = (m == 1) ? 0 : s - VTH;
                    end else begin
                        r1_sp[m][k] = 1'b0;
                        vm[m][c][k] = s;
                    end
                end
            end
        end
        done_exp = (rem == 1) && !clr;
        if (clr) begin
            rem = NUM;
            for (int m = 0; m < 2; m++)
                for (int cc = 0; cc < NUM; cc++)
                    for (int k = 0; k < 4; k++) vm[m][cc][k] = 0;
        end else if (rem > 0) begin
            rem--;
        end
        clr_last = clr;

        mp_valid  = v;
        clear_req = clr;
        ch        = CW'(c);
        mp1       = MW'(a0);
        mp2       = MW'(a1);
        mp3       = MW'(a2);
        mp4       = MW'(a3);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic do_reset(input int cyc);
        rstn      = 1'b0;
        mp_valid  = 1'b0;
        clear_req = 1'b0;
        repeat (cyc) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("rst_spike[%0d]", m), 32'(spk[m]), 32'd0);
            check($sformatf("rst_spike_channel[%0d]", m), 32'(spk_ch[m]), 32'd0);
            check($sformatf("rst_spike_valid[%0d]", m), 32'(spk_v[m]), 32'd0);
            check($sformatf("rst_busy[%0d]", m), 32'(bsy[m]), 32'd1);
            check($sformatf("rst_clear_done[%0d]", m), 32'(cdone[m]), 32'd0);
            check($sformatf("rst_spike_cnt[%0d]", m), 32'(scnt[m]), 32'd0);
            check($sformatf("rst_overrun[%0d]", m), 32'(ovr[m]), 32'd0);
        end
        rstn = 1'b1;
        model_reset();
    endtask

    function automatic int rmp();
        int t;
        case ($urandom_range(0, 9))
            0:       t = VMAX;
            1:       t = VMIN;
            2, 3:    t = int'($urandom_range(0, 65535)) - 32768;
            default: t = int'($urandom_range(0, 160)) - 60;
        endcase
        return t;
    endfunction

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete within cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        int r;
        int c;
        int last_c;
        bit v;
        bit cl;

        rstn = 1'b0; mp_valid = 1'b0; clear_req = 1'b0; ch = '0;
        mp1 = '0; mp2 = '0; mp3 = '0; mp4 = '0;
        last_c = 0;
        do_reset(3);

        // Automatic sweep after reset
        nb = 0;
        for (int i = 0; i < 140; i++) begin
            if (bsy[0]) nb++;
            idle();
        end
        check("busy_cycles", 32'(nb), 32'(NUM));

        for (int i = 0; i < NUM; i++) step(1'b1, i, 0, 0, 0, 0, 1'b0);

        repeat (3) step(1'b1, 5, 30, 30, 30, 30, 1'b0);
        step(1'b1, 3, 100, -40, 0, 0, 1'b0);
        step(1'b1, 7, 40, 0, 0, 0, 1'b0);
        step(1'b1, 7, 40, 0, 0, 0, 1'b0);
        step(1'b1, 7, 40, 0, 0, 0, 1'b0);
        step(1'b1, 11, 64, 63, -64, 0, 1'b0);
        step(1'b1, 11, 0, 1, 0, 0, 1'b0);
        repeat (2) step(1'b1, 9, VMAX, VMAX, VMIN, VMIN, 1'b0);
        step(1'b1, 9, 0, 0, VMIN, -1, 1'b0);
        step(1'b1, 128, 500, 500, 500, 500, 1'b0);
        step(1'b1, 255, 500, 500, 500, 500, 1'b0);
        step(1'b1, 3, 0, 0, 0, 0, 1'b0);
        idle(); idle();

        // Clear, op three cycles later is dropped
        step(1'b0, 0, 0, 0, 0, 0, 1'b1);
        idle(); idle();
        step(1'b1, 5, 100, 100, 100, 100, 1'b0);
        repeat (130) idle();
        step(1'b1, 5, 10, 0, 0, 70, 1'b0);

        // Clear restarted mid-sweep
        step(1'b0, 0, 0, 0, 0, 0, 1'b1);
        repeat (50) idle();
        step(1'b0, 0, 0, 0, 0, 0, 1'b1);
        repeat (130) idle();

        // Clear and op in the same cycle, op in the cycle before a clear
        do_reset(2);
        repeat (130) idle();
        step(1'b1, 6, 90, 0, 0, 0, 1'b0);
        step(1'b1, 4, 100, 100, 100, 100, 1'b1);
        repeat (130) idle();
        step(1'b1, 6, 0, 0, 0, 0, 1'b0);
        idle(); idle();

        // Randomized traffic with occasional clears and mid-run resets
        do_reset(2);
        repeat (130) idle();
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 999));
            if (r == 0) begin
                do_reset(2);
            end else begin
                v  = ($urandom_range(0, 9) < 8);
                cl = (r < 6);
                c  = ($urandom_range(0, 3) == 0) ? last_c : int'($urandom_range(0, 140));
                step(v, c, rmp(), rmp(), rmp(), rmp(), cl);
                last_c = c;
            end
        end
        idle(); idle();

        // Drive the spike counter into saturation
        do_reset(2);
        repeat (130) idle();
        for (int i = 0; i < 16500; i++) step(1'b1, int'($urandom_range(0, NUM - 1)), VMAX, VMAX, VMAX, VMAX, 1'b0);
        idle(); idle();
        check("spike_cnt_saturated", 32'(scnt[0]), 32'd65535);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
